// File: rtl/axis_to_avs_bridge.sv
// Purpose: AXI4-Stream sink to Avalon-ST source bridge (SOP/EOP framing, empty, channel, error).
// Latency: a beat accepted on edge t is presented on the Avalon-ST outputs from edge t+1.
// Backpressure: 2-entry skid buffer; axis_tready is registered and drops once both entries are full.
module axis_to_avs_bridge #(
    parameter  int N       = 4,
    parameter  int I       = 1,
    localparam int EMPTY_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 axis_tvalid,
    output logic                 axis_tready,
    input  logic [8*N-1:0]       axis_tdata,
    input  logic [N-1:0]         axis_tkeep,
    input  logic                 axis_tlast,
    input  logic [I-1:0]         axis_tid,
    output logic                 avs_valid,
    input  logic                 avs_ready,
    output logic [8*N-1:0]       avs_data,
    output logic                 avs_startofpacket,
    output logic                 avs_endofpacket,
    output logic [EMPTY_W-1:0]   avs_empty,
    output logic [I-1:0]         avs_channel,
    output logic                 avs_error,
    output logic [15:0]          pkt_count
);

    // One fully formatted Avalon-ST beat, as stored in the skid buffer.
    typedef struct packed {
        logic [8*N-1:0]     data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [I-1:0]       channel;
        logic               error;
    } beat_t;

    localparam logic [N-1:0] KEEP_ONE = {{(N-1){1'b0}}, 1'b1};

    // head_q drives the outputs directly; skid_q holds the second beat while stalled.
    beat_t          head_q;
    beat_t          skid_q;
    beat_t          beat_in;
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    logic           tready_q;
    logic           valid_q;
    logic           in_pkt_q;
    logic [I-1:0]   sop_tid_q;
    logic [15:0]    pkt_count_q;

    logic           accept;
    logic           deliver;

    logic [8*N-1:0] data_rev;
    logic [31:0]    keep_cnt;
    logic [31:0]    empty_full;
    logic [N-1:0]   keep_plus;
    logic           keep_all;
    logic           keep_zero;
    logic           keep_contig;
    logic           tid_err;

    assign accept  = axis_tvalid & tready_q;
    assign deliver = valid_q & avs_ready;

    // Byte 0 of the AXIS word becomes the first (most significant) Avalon symbol.
    always_comb begin
        data_rev = '0;
        for (int k = 0; k < N; k++) begin
            data_rev[8*(N-1-k) +: 8] = axis_tdata[8*k +: 8];
        end
    end

    // Count kept bytes to derive the number of unused symbols on the last beat.
    always_comb begin
        keep_cnt = '0;
        for (int k = 0; k < N; k++) begin
            keep_cnt = keep_cnt + 32'(axis_tkeep[k]);
        end
    end

    assign empty_full  = 32'(N) - keep_cnt;
    assign keep_all    = &axis_tkeep;
    assign keep_zero   = ~|axis_tkeep;
    assign keep_plus   = axis_tkeep + KEEP_ONE;
    // A mask of the form 0..01..1 has no bit in common with itself plus one.
    assign keep_contig = ((axis_tkeep & keep_plus) == '0);
    // Channel is checked against the tid latched on the packet's first beat.
    assign tid_err     = in_pkt_q & (axis_tid != sop_tid_q);

    // Build the outgoing beat from the current AXIS inputs and framing state.
    always_comb begin
        beat_in         = '0;
        beat_in.data    = data_rev;
        beat_in.sop     = ~in_pkt_q;
        beat_in.eop     = axis_tlast;
        beat_in.channel = axis_tid;
        if (axis_tlast && (N > 1)) begin
            beat_in.empty = empty_full[EMPTY_W-1:0];
        end
        beat_in.error   = keep_zero | ~keep_contig | (~axis_tlast & ~keep_all) | tid_err;
    end

    // Occupancy follows accept/deliver; simultaneous accept and deliver leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({accept, deliver})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Skid buffer storage, occupancy and the registered handshake outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            head_q   <= '0;
            skid_q   <= '0;
            count_q  <= 2'd0;
            tready_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) head_q <= beat_in;
                end
                2'd1: begin
                    if (accept && deliver) begin
                        head_q <= beat_in;
                    end else if (accept) begin
                        skid_q <= beat_in;
                    end
                end
                2'd2: begin
                    if (deliver) head_q <= skid_q;
                end
                default: ;
            endcase
            count_q  <= count_d;
            tready_q <= (count_d != 2'd2);
            valid_q  <= (count_d != 2'd0);
        end
    end

    // Packet framing state: in_pkt and the tid of the current packet's first beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            in_pkt_q  <= 1'b0;
            sop_tid_q <= '0;
        end else if (accept) begin
            if (!in_pkt_q) sop_tid_q <= axis_tid;
            in_pkt_q <= ~axis_tlast;
        end
    end

    // Count packets as their last beat leaves downstream; wraps naturally.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count_q <= 16'd0;
        end else if (deliver && head_q.eop) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign axis_tready       = tready_q;
    assign avs_valid         = valid_q;
    assign avs_data          = head_q.data;
    assign avs_startofpacket = head_q.sop;
    assign avs_endofpacket   = head_q.eop;
    assign avs_empty         = head_q.empty;
    assign avs_channel       = head_q.channel;
    assign avs_error         = head_q.error;
    assign pkt_count         = pkt_count_q;

endmodule
